// File: rtl/modbus_rx_framer.sv
// Modbus RTU receive framer: buffers one frame, checks CRC-16 and station address, then holds it for the controller.
// Optional statistics counters are compiled in when MODBUS_RX_STATS_EN is defined.
module modbus_rx_framer #(
    parameter int MAX_LEN = 256,
    parameter int AW      = 8
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic [7:0]    slave_addr_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          frame_start_i,
    input  logic          frame_end_i,
    input  logic          frame_timeout_i,
    output logic          frm_valid_o,
    output logic [AW:0]   frm_len_o,
    output logic          frm_bcast_o,
    input  logic          frm_ack_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          crc_err_o,
    output logic          ovf_err_o,
    output logic          addr_miss_o,
    output logic          busy_drop_o,
`ifdef MODBUS_RX_STATS_EN
    input  logic          stat_clr_i,
    output logic [15:0]   stat_good_o,
    output logic [15:0]   stat_crc_o,
    output logic [15:0]   stat_drop_o,
`endif
    output logic          abort_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [AW:0] LEN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LEN_TWO  = {{(AW-1){1'b0}}, 2'b10};
    localparam logic [AW:0] LEN_FOUR = {{(AW-2){1'b0}}, 3'b100};
    localparam logic [AW:0] LEN_MAX  = MAX_LEN[AW:0];

    logic [1:0]  state;
    logic [15:0] crc;
    logic [AW:0] len;
    logic        ovf;
    logic [7:0]  addr;
    logic [7:0]  mem [0:MAX_LEN-1];

    logic restart;
    logic take_byte;
    logic write_en;
    logic addr_ok;
    logic frame_bad;
    logic ev_good;
    logic ev_crc;
    logic ev_ovf;
    logic ev_miss;
    logic ev_busy;
    logic ev_abort;

    // One whole byte through the reflected 0xA001 polynomial per call.
    function automatic logic [15:0] crc_next(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Timeout beats a restart, a restart beats byte/end handling; an ack in HOLD beats busy_drop.
    always_comb begin
        restart   = ((state == IDLE) && frame_start_i)
                 || ((state == RECV) && !frame_timeout_i && frame_start_i)
                 || ((state == HOLD) && frm_ack_i && frame_start_i);
        take_byte = (state == RECV) && !frame_timeout_i && !frame_start_i && rx_valid_i;
        write_en  = take_byte && (len < LEN_MAX);
        addr_ok   = (addr == 8'h00) || (addr == slave_addr_i);
        frame_bad = (len < LEN_FOUR) || (crc != 16'h0000);
        ev_ovf    = (state == CHECK) && ovf;
        ev_crc    = (state == CHECK) && !ovf && frame_bad;
        ev_good   = (state == CHECK) && !ovf && !frame_bad && addr_ok;
        ev_miss   = (state == CHECK) && !ovf && !frame_bad && !addr_ok;
        ev_busy   = (state == HOLD) && frame_start_i && !frm_ack_i;
        ev_abort  = (state == RECV) && frame_timeout_i;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            crc         <= 16'hFFFF;
            len         <= '0;
            ovf         <= 1'b0;
            addr        <= 8'h00;
            frm_valid_o <= 1'b0;
            frm_len_o   <= '0;
            frm_bcast_o <= 1'b0;
        end else if (restart) begin
            state       <= RECV;
            crc         <= 16'hFFFF;
            len         <= '0;
            ovf         <= 1'b0;
            frm_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                RECV: begin
                    if (frame_timeout_i) begin
                        state <= IDLE;
                    end else begin
                        if (take_byte) begin
                            if (write_en) begin
                                crc <= crc_next(crc, rx_data_i);
                                len <= len + LEN_ONE;
                                if (len == '0) addr <= rx_data_i;
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                        if (frame_end_i) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (ev_good) begin
                        state       <= HOLD;
                        frm_valid_o <= 1'b1;
                        frm_len_o   <= len - LEN_TWO;
                        frm_bcast_o <= (addr == 8'h00);
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (frm_ack_i) begin
                        state       <= IDLE;
                        frm_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            crc_err_o   <= 1'b0;
            ovf_err_o   <= 1'b0;
            addr_miss_o <= 1'b0;
            busy_drop_o <= 1'b0;
            abort_o     <= 1'b0;
        end else begin
            crc_err_o   <= ev_crc;
            ovf_err_o   <= ev_ovf;
            addr_miss_o <= ev_miss;
            busy_drop_o <= ev_busy;
            abort_o     <= ev_abort;
        end
    end

    // Frame buffer is a plain RAM with no reset so it maps onto block memory.
    always_ff @(posedge PCLK) begin
        if (write_en) mem[len[AW-1:0]] <= rx_data_i;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) rd_data_o <= 8'h00;
        else          rd_data_o <= mem[rd_addr_i];
    end

`ifdef MODBUS_RX_STATS_EN
    logic ev_drop;
    assign ev_drop = ev_ovf || ev_miss || ev_busy || ev_abort;

    // Saturating counters; a clear in the same cycle as an event wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            stat_good_o <= 16'h0000;
            stat_crc_o  <= 16'h0000;
            stat_drop_o <= 16'h0000;
        end else if (stat_clr_i) begin
            stat_good_o <= 16'h0000;
            stat_crc_o  <= 16'h0000;
            stat_drop_o <= 16'h0000;
        end else begin
            if (ev_good && (stat_good_o != 16'hFFFF)) stat_good_o <= stat_good_o + 16'd1;
            if (ev_crc  && (stat_crc_o  != 16'hFFFF)) stat_crc_o  <= stat_crc_o + 16'd1;
            if (ev_drop && (stat_drop_o != 16'hFFFF)) stat_drop_o <= stat_drop_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_modbus_rx_framer.sv
// Self-checking bench for modbus_rx_framer: directed frames plus randomized frames judged by a frame-level model.
// Statistics checks are compiled in when MODBUS_RX_STATS_EN is defined.
module tb_modbus_rx_framer;

    localparam int MAX_LEN = 256;
    localparam int AW      = 8;
    localparam int K_GOOD  = 0;
    localparam int K_CRC   = 1;
    localparam int K_OVF   = 2;
    localparam int K_MISS  = 3;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic [7:0]    slave_addr = 8'h01;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end = 1'b0;
    logic          frame_timeout = 1'b0;
    logic          frm_valid;
    logic [AW:0]   frm_len;
    logic          frm_bcast;
    logic          frm_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          crc_err;
    logic          ovf_err;
    logic          addr_miss;
    logic          busy_drop;
    logic          abort_pulse;
`ifdef MODBUS_RX_STATS_EN
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_good;
    logic [15:0]   stat_crc;
    logic [15:0]   stat_drop;
`endif

    int checks = 0;
    int failures = 0;
    int cnt_crc = 0, cnt_ovf = 0, cnt_miss = 0, cnt_busy = 0, cnt_abort = 0;
    int exp_good = 0, exp_crc = 0, exp_drop = 0;
    logic [7:0] tx_q[$];
    logic [7:0] held_q[$];

    modbus_rx_framer #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .PCLK            (pclk),
        .PRESETn         (presetn),
        .slave_addr_i    (slave_addr),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .frame_start_i   (frame_start),
        .frame_end_i     (frame_end),
        .frame_timeout_i (frame_timeout),
        .frm_valid_o     (frm_valid),
        .frm_len_o       (frm_len),
        .frm_bcast_o     (frm_bcast),
        .frm_ack_i       (frm_ack),
        .rd_addr_i       (rd_addr),
        .rd_data_o       (rd_data),
        .crc_err_o       (crc_err),
        .ovf_err_o       (ovf_err),
        .addr_miss_o     (addr_miss),
        .busy_drop_o     (busy_drop),
`ifdef MODBUS_RX_STATS_EN
        .stat_clr_i      (stat_clr),
        .stat_good_o     (stat_good),
        .stat_crc_o      (stat_crc),
        .stat_drop_o     (stat_drop),
`endif
        .abort_o         (abort_pulse)
    );

    always #5 pclk = ~pclk;

    // Pulse counters sampled mid-cycle; a pulse wider than one cycle shows up as an extra count.
    always @(negedge pclk) begin
        if (crc_err)     cnt_crc++;
        if (ovf_err)     cnt_ovf++;
        if (addr_miss)   cnt_miss++;
        if (busy_drop)   cnt_busy++;
        if (abort_pulse) cnt_abort++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] modelCrc(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, tx_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Frame-level verdict: overflow, then length/CRC (CRC sent low byte first), then address.
    function automatic int modelKind(input logic [7:0] saddr);
        int n = tx_q.size();
        if (n > MAX_LEN) return K_OVF;
        if (n < 4) return K_CRC;
        if (modelCrc(n - 2) != {tx_q[n-1], tx_q[n-2]}) return K_CRC;
        if (tx_q[0] == 8'h00 || tx_q[0] == saddr) return K_GOOD;
        return K_MISS;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic buildFrame(input logic [7:0] a, input int payload);
        logic [15:0] c;
        tx_q.delete();
        tx_q.push_back(a);
        for (int i = 0; i < payload; i++) tx_q.push_back(8'($urandom));
        c = modelCrc(tx_q.size());
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
    endtask

    task automatic applyStimulus(input bit with_ack, input int gap_max, input bit end_with_last);
        frame_start = 1'b1;
        frm_ack = with_ack;
        step();
        frame_start = 1'b0;
        frm_ack = 1'b0;
        for (int i = 0; i < tx_q.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) step();
            rx_data = tx_q[i];
            rx_valid = 1'b1;
            if (end_with_last && i == tx_q.size() - 1) frame_end = 1'b1;
            step();
            rx_valid = 1'b0;
        end
        if (end_with_last) begin
            frame_end = 1'b0;
        end else begin
            frame_end = 1'b1;
            step();
            frame_end = 1'b0;
        end
    endtask

    task automatic readPayload(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            step();
            checkOutput(tag, rd_data, tx_q[i]);
        end
    endtask

    task automatic runFrame(input bit with_ack, input int gap_max, input bit end_with_last,
                            input bit do_ack, input string tag);
        int kind, n, b_crc, b_ovf, b_miss, b_busy, b_abort;
        kind = modelKind(slave_addr);
        n = tx_q.size();
        b_crc = cnt_crc; b_ovf = cnt_ovf; b_miss = cnt_miss; b_busy = cnt_busy; b_abort = cnt_abort;
        applyStimulus(with_ack, gap_max, end_with_last);
        step();
        checkOutput({tag, "_valid"}, frm_valid, kind == K_GOOD);
        step();
        checkOutput({tag, "_crc_pulses"}, cnt_crc - b_crc, kind == K_CRC);
        checkOutput({tag, "_ovf_pulses"}, cnt_ovf - b_ovf, kind == K_OVF);
        checkOutput({tag, "_miss_pulses"}, cnt_miss - b_miss, kind == K_MISS);
        checkOutput({tag, "_busy_pulses"}, cnt_busy - b_busy, 0);
        checkOutput({tag, "_abort_pulses"}, cnt_abort - b_abort, 0);
        case (kind)
            K_GOOD: exp_good++;
            K_CRC:  exp_crc++;
            default: exp_drop++;
        endcase
        if (kind == K_GOOD) begin
            checkOutput({tag, "_len"}, frm_len, n - 2);
            checkOutput({tag, "_bcast"}, frm_bcast, tx_q[0] == 8'h00);
            readPayload({tag, "_rd"}, n - 2);
            if (do_ack) begin
                frm_ack = 1'b1;
                step();
                frm_ack = 1'b0;
                checkOutput({tag, "_ack_valid"}, frm_valid, 0);
            end
        end
    endtask

    task automatic checkStats(input string tag);
`ifdef MODBUS_RX_STATS_EN
        checkOutput({tag, "_stat_good"}, stat_good, exp_good);
        checkOutput({tag, "_stat_crc"}, stat_crc, exp_crc);
        checkOutput({tag, "_stat_drop"}, stat_drop, exp_drop);
`endif
    endtask

    initial begin
        int b_crc, b_ovf, b_miss, b_busy, b_abort;
        logic [15:0] c;
        $display("[TB] start");

        // Reset state
        step();
        step();
        checkOutput("rst_valid", frm_valid, 0);
        checkOutput("rst_len", frm_len, 0);
        checkOutput("rst_bcast", frm_bcast, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_pulses", cnt_crc + cnt_ovf + cnt_miss + cnt_busy + cnt_abort, 0);
        checkStats("rst");
        presetn = 1'b1;
        step();

        // Reference frame, corrupted CRC, short frame
        slave_addr = 8'h01;
        tx_q = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h8C, 8'h3A};
        runFrame(1'b0, 0, 1'b0, 1'b1, "ref");
        tx_q = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h8C, 8'h3B};
        runFrame(1'b0, 0, 1'b0, 1'b1, "badcrc");
        tx_q = '{8'h01, 8'h05, 8'h00};
        runFrame(1'b0, 0, 1'b0, 1'b1, "short");

        // Foreign address, then broadcast left held to exercise reset mid-HOLD
        tx_q = '{8'h02, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00};
        c = modelCrc(6);
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        runFrame(1'b0, 1, 1'b0, 1'b1, "miss");
        buildFrame(8'h00, 5);
        runFrame(1'b0, 1, 1'b1, 1'b0, "bcast");
        checkStats("pre_rst");
        presetn = 1'b0;
        #2;
        checkOutput("midrst_valid", frm_valid, 0);
        checkOutput("midrst_bcast", frm_bcast, 0);
        checkOutput("midrst_len", frm_len, 0);
        checkOutput("midrst_rd_data", rd_data, 0);
        exp_good = 0; exp_crc = 0; exp_drop = 0;
        checkStats("midrst");
        step();
        presetn = 1'b1;
        step();

`ifdef MODBUS_RX_STATS_EN
        buildFrame(slave_addr, 2);
        runFrame(1'b0, 0, 1'b0, 1'b1, "pre_clr");
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        exp_good = 0; exp_crc = 0; exp_drop = 0;
        checkStats("clr");
`endif

        // Overflow: 257 bytes
        tx_q.delete();
        for (int i = 0; i < MAX_LEN + 1; i++) tx_q.push_back(8'($urandom));
        runFrame(1'b0, 0, 1'b0, 1'b1, "ovf");
        checkStats("ovf");

        // Timeout after three bytes, then prove the framer is back in IDLE
        buildFrame(slave_addr, 4);
        b_abort = cnt_abort; b_crc = cnt_crc; b_miss = cnt_miss; b_ovf = cnt_ovf;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_data = tx_q[i];
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
        end
        frame_timeout = 1'b1;
        step();
        frame_timeout = 1'b0;
        step();
        checkOutput("tmo_abort_pulses", cnt_abort - b_abort, 1);
        checkOutput("tmo_valid", frm_valid, 0);
        exp_drop++;
        rx_data = tx_q[3];
        rx_valid = 1'b1;
        frame_end = 1'b1;
        step();
        rx_valid = 1'b0;
        frame_end = 1'b0;
        step();
        step();
        checkOutput("idle_err_pulses", (cnt_crc - b_crc) + (cnt_miss - b_miss) + (cnt_ovf - b_ovf), 0);
        checkOutput("idle_valid", frm_valid, 0);
        runFrame(1'b0, 1, 1'b0, 1'b1, "post_tmo");

        // Held frame, then a second frame while busy
        buildFrame(slave_addr, 4);
        runFrame(1'b0, 0, 1'b0, 1'b0, "hold");
        held_q = tx_q;
        b_busy = cnt_busy; b_crc = cnt_crc;
        buildFrame(slave_addr, 4);
        applyStimulus(1'b0, 0, 1'b0);
        step();
        step();
        checkOutput("busy_pulses", cnt_busy - b_busy, 1);
        checkOutput("busy_crc_pulses", cnt_crc - b_crc, 0);
        checkOutput("busy_valid", frm_valid, 1);
        checkOutput("busy_len", frm_len, held_q.size() - 2);
        exp_drop++;
        tx_q = held_q;
        readPayload("busy_rd", held_q.size() - 2);
        buildFrame(slave_addr, 3);
        runFrame(1'b1, 0, 1'b0, 1'b1, "ackstart");

        // Randomized frames judged by the model
        for (int t = 0; t < 24; t++) begin
            logic [7:0] a;
            int sel;
            slave_addr = 8'($urandom_range(247, 1));
            sel = $urandom_range(2, 0);
            a = (sel == 0) ? 8'h00 : (sel == 1) ? slave_addr : slave_addr + 8'd1;
            if ($urandom_range(7, 0) == 0) begin
                tx_q.delete();
                for (int i = 0; i < $urandom_range(3, 1); i++) tx_q.push_back(8'($urandom));
            end else begin
                buildFrame(a, $urandom_range(8, 1));
                if ($urandom_range(3, 0) == 0)
                    tx_q[$urandom_range(tx_q.size() - 1, 0)] ^= 8'(1 << $urandom_range(7, 0));
            end
            runFrame(1'b0, 2, 1'($urandom_range(1, 0)), 1'b1, "rnd");
        end
        checkStats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
